// File: rtl/rom_sine_reader.sv
// rom_sine_reader: read-side master for a 256x16 sine ROM macro.
// A phase accumulator produces ROM addresses, one-cycle read strobes are
// issued to the macro, and the returned words are buffered in a small FIFO
// and streamed out over a valid/ready sample interface.
//
// Optional feature macro: QUARTER_WAVE_EN
//   defined   -> the ROM holds a quarter-wave table; the quadrant bits mirror
//                the address and negate the returned word.
//   undefined -> full-wave table, top ADDR_WIDTH phase bits are the address.
module rom_sine_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk0_i,
  input  logic                   rst0_i,
  input  logic                   en_i,
  input  logic [PHASE_WIDTH-1:0] phase_inc_i,
  input  logic                   phase_load_i,
  input  logic [PHASE_WIDTH-1:0] phase_init_i,
  output logic                   rom_cs0_o,
  output logic [ADDR_WIDTH-1:0]  rom_addr0_o,
  input  logic [DATA_WIDTH-1:0]  rom_dout0_i,
  output logic [DATA_WIDTH-1:0]  sample_o,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = OCC_W + 1;

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   cs_q, cs_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  issue_addr;
  logic                   rd_p1_q;

  logic [DATA_WIDTH-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;

  logic [CNT_W-1:0]       pending;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  cap_word;

`ifdef QUARTER_WAVE_EN
  logic                   neg_p0_q, neg_p0_d;
  logic                   neg_p1_q;
  logic [1:0]             quadrant;
  logic [ADDR_WIDTH-1:0]  idx;

  // Quarter-wave folding: odd quadrants walk the table backwards, the upper
  // half-period negates the word once it comes back from the ROM.
  always_comb begin
    quadrant   = phase_q[PHASE_WIDTH-1 -: 2];
    idx        = phase_q[PHASE_WIDTH-3 -: ADDR_WIDTH];
    issue_addr = quadrant[0] ? ~idx : idx;
    cap_word   = neg_p1_q ? (DATA_WIDTH'(0) - rom_dout0_i) : rom_dout0_i;
  end
`else
  assign issue_addr = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign cap_word   = rom_dout0_i;
`endif

  // Words already committed: buffered, on the ROM port, and inside the ROM.
  // Counting the in-flight ones guarantees every capture finds a free slot.
  assign pending = CNT_W'(occ_q) + CNT_W'(cs_q) + CNT_W'(rd_p1_q);
  assign issue   = en_i && !phase_load_i && (pending < CNT_W'(FIFO_DEPTH));
  assign push    = rd_p1_q;
  assign pop     = sample_valid_o && sample_ready_i;

  // Issue logic: a load wins over an issue; an issue strobes the ROM for one
  // cycle and advances the phase by the step presented this cycle.
  always_comb begin
    phase_d = phase_q;
    cs_d    = 1'b0;
    addr_d  = addr_q;
`ifdef QUARTER_WAVE_EN
    neg_p0_d = 1'b0;
`endif
    if (phase_load_i) begin
      phase_d = phase_init_i;
    end else if (issue) begin
      cs_d    = 1'b1;
      addr_d  = issue_addr;
      phase_d = phase_q + phase_inc_i;
`ifdef QUARTER_WAVE_EN
      neg_p0_d = quadrant[1];
`endif
    end
  end

  // FIFO bookkeeping; pointers wrap naturally since the depth is a power of 2.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

  // Read pipeline registers: ROM port outputs and the capture flag that
  // marks the edge where the ROM data is valid.
  always_ff @(posedge clk0_i or posedge rst0_i) begin
    if (rst0_i) begin
      phase_q <= '0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      rd_p1_q <= 1'b0;
`ifdef QUARTER_WAVE_EN
      neg_p0_q <= 1'b0;
      neg_p1_q <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      rd_p1_q <= cs_q;
`ifdef QUARTER_WAVE_EN
      neg_p0_q <= neg_p0_d;
      neg_p1_q <= neg_p0_q;
`endif
    end
  end

  // Sample buffer: ROM data is only written on capture edges, so X on the
  // ROM output at any other time never reaches the storage.
  always_ff @(posedge clk0_i or posedge rst0_i) begin
    if (rst0_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= cap_word;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rom_cs0_o      = cs_q;
  assign rom_addr0_o    = addr_q;
  assign sample_o       = fifo_q[rd_ptr_q];
  assign sample_valid_o = (occ_q != '0);

endmodule

// File: tb/tb_rom_sine_reader.sv
// tb_rom_sine_reader: scoreboard bench for rom_sine_reader with a
// behavioural ROM macro (mem[i] = i*16'h0101). Inputs change on the falling
// edge, outputs are observed on the falling edge.
module tb_rom_sine_reader;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int PW    = 24;
  localparam int DEPTH = 4;
`ifdef QUARTER_WAVE_EN
  localparam logic [PW-1:0] INC = 24'h004000;
`else
  localparam logic [PW-1:0] INC = 24'h010000;
`endif

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          en = 1'b0;
  logic [PW-1:0] phase_inc = '0;
  logic          phase_load = 1'b0;
  logic [PW-1:0] phase_init = '0;
  logic          rom_cs0;
  logic [AW-1:0] rom_addr0;
  logic [DW-1:0] rom_dout0;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready = 1'b0;

  int            n_vec = 0;
  int            n_err = 0;
  int            n_issue = 0;
  int            n_pop = 0;
  logic [DW-1:0] sb_q[$];
  logic [PW-1:0] mp = '0;

  always #5 clk0 = ~clk0;

  rom_sine_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PHASE_WIDTH(PW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk0_i(clk0), .rst0_i(rst0), .en_i(en),
    .phase_inc_i(phase_inc), .phase_load_i(phase_load), .phase_init_i(phase_init),
    .rom_cs0_o(rom_cs0), .rom_addr0_o(rom_addr0), .rom_dout0_i(rom_dout0),
    .sample_o(sample), .sample_valid_o(sample_valid), .sample_ready_i(sample_ready)
  );

  // Behavioural ROM: registers cs/addr on the rising edge, output goes X
  // shortly after the next rising edge and the word appears after the negedge.
  logic [DW-1:0] rom_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = DW'(i) * 16'h0101;
    rom_dout0 = 'x;
  end

  always @(posedge clk0) begin : rom_model
    logic          rd_cs;
    logic [AW-1:0] rd_a;
    rd_cs = rom_cs0;
    rd_a  = rom_addr0;
    #1 rom_dout0 = 'x;
    @(negedge clk0);
    #2 if (rd_cs) rom_dout0 = rom_mem[rd_a];
  end

  function automatic logic [AW-1:0] exp_addr(input logic [PW-1:0] p);
`ifdef QUARTER_WAVE_EN
    logic [1:0]    q;
    logic [AW-1:0] ix;
    q  = p[PW-1 -: 2];
    ix = p[PW-3 -: AW];
    return q[0] ? ~ix : ix;
`else
    return p[PW-1 -: AW];
`endif
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [PW-1:0] p);
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    a = exp_addr(p);
    w = {a, a};
`ifdef QUARTER_WAVE_EN
    if (p[PW-1]) w = -w;
`endif
    return w;
  endfunction

  // One clock: remember what the DUT sees at the coming edge, then score the
  // transfer, any new issue and the buffer bound on the following negedge.
  task automatic cycle();
    logic          xfer, ld_s, en_s;
    logic [DW-1:0] xdata, exp_w;
    logic [PW-1:0] init_s, inc_s;
    xfer   = sample_valid && sample_ready;
    xdata  = sample;
    ld_s   = phase_load;
    en_s   = en;
    init_s = phase_init;
    inc_s  = phase_inc;
    @(negedge clk0);
    if (xfer) begin
      n_pop++;
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL pop_order: got %h, want nothing (scoreboard empty)", xdata);
      end else begin
        exp_w = sb_q.pop_front();
        if (xdata !== exp_w) begin
          n_err++;
          $display("[TB] FAIL pop_order: got %h, want %h", xdata, exp_w);
        end
      end
    end
    if (rom_cs0 === 1'b1) begin
      n_issue++;
      n_vec++;
      if (ld_s || !en_s) begin
        n_err++;
        $display("[TB] FAIL issue_rule: got issue with load=%0b en=%0b, want none", ld_s, en_s);
      end
      n_vec++;
      if (rom_addr0 !== exp_addr(mp)) begin
        n_err++;
        $display("[TB] FAIL issue_addr: got %h, want %h", rom_addr0, exp_addr(mp));
      end
      sb_q.push_back(exp_word(mp));
      mp = mp + inc_s;
    end else if (ld_s) begin
      mp = init_s;
    end
    n_vec++;
    if (sb_q.size() > DEPTH) begin
      n_err++;
      $display("[TB] FAIL overflow: got %0d words committed, want <= %0d", sb_q.size(), DEPTH);
    end
  endtask

  task automatic do_reset();
    @(negedge clk0);
    rst0 = 1'b1;
    en = 1'b0;
    phase_load = 1'b0;
    sample_ready = 1'b0;
    phase_inc = INC;
    phase_init = '0;
    sb_q.delete();
    mp = '0;
    repeat (2) @(negedge clk0);
    rst0 = 1'b0;
  endtask

  task automatic drain();
    int k;
    en = 1'b0;
    sample_ready = 1'b1;
    k = 0;
    while ((sb_q.size() != 0 || sample_valid) && k < 50) begin
      cycle();
      k++;
    end
    n_vec++;
    if (sb_q.size() != 0 || sample_valid) begin
      n_err++;
      $display("[TB] FAIL drain_timeout: got %0d words left, want 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    en = 1'b1;
    sample_ready = 1'b1;
    phase_inc = INC;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_vec += 3;
      if (rom_cs0 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_cs: got %b, want 0", rom_cs0); end
      if (sample_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b, want 0", sample_valid); end
      if (sample !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_sample: got %h, want 0000", sample); end
    end
  endtask

  task automatic test_latency();
    int p0;
    do_reset();
    sample_ready = 1'b1;
    en = 1'b1;
    cycle();
    n_vec += 3;
    if (rom_cs0 !== 1'b1) begin n_err++; $display("[TB] FAIL lat_cs: got %b, want 1", rom_cs0); end
    if (rom_addr0 !== 8'h00) begin n_err++; $display("[TB] FAIL lat_addr0: got %h, want 00", rom_addr0); end
    if (sample_valid !== 1'b0) begin n_err++; $display("[TB] FAIL lat_valid_k: got %b, want 0", sample_valid); end
    cycle();
    n_vec += 2;
    if (rom_addr0 !== 8'h01) begin n_err++; $display("[TB] FAIL lat_addr1: got %h, want 01", rom_addr0); end
    if (sample_valid !== 1'b0) begin n_err++; $display("[TB] FAIL lat_valid_k1: got %b, want 0", sample_valid); end
    cycle();
    n_vec += 2;
    if (sample_valid !== 1'b1) begin n_err++; $display("[TB] FAIL lat_valid_k2: got %b, want 1", sample_valid); end
    if (sample !== 16'h0000) begin n_err++; $display("[TB] FAIL lat_first: got %h, want 0000", sample); end
    p0 = n_pop;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_vec += 2;
      if (sample_valid !== 1'b1) begin n_err++; $display("[TB] FAIL thru_valid: got %b, want 1", sample_valid); end
      if (sample !== DW'((i + 1) * 16'h0101)) begin
        n_err++;
        $display("[TB] FAIL thru_sample: got %h, want %h", sample, DW'((i + 1) * 16'h0101));
      end
    end
    n_vec++;
    if (n_pop - p0 != 10) begin n_err++; $display("[TB] FAIL thru_rate: got %0d pops, want 10", n_pop - p0); end
    drain();
  endtask

  task automatic test_backpressure();
    int i0, p0;
    do_reset();
    sample_ready = 1'b0;
    en = 1'b1;
    i0 = n_issue;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i >= 2) begin
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 16'h0000) begin
          n_err++;
          $display("[TB] FAIL bp_hold: got valid=%b sample=%h, want valid=1 sample=0000", sample_valid, sample);
        end
      end
    end
    n_vec += 2;
    if (n_issue - i0 != DEPTH) begin n_err++; $display("[TB] FAIL bp_issues: got %0d, want %0d", n_issue - i0, DEPTH); end
    if (sb_q.size() != DEPTH) begin n_err++; $display("[TB] FAIL bp_buffered: got %0d, want %0d", sb_q.size(), DEPTH); end
    sample_ready = 1'b1;
    p0 = n_pop;
    repeat (12) cycle();
    n_vec++;
    if (n_pop - p0 != 12) begin n_err++; $display("[TB] FAIL bp_resume: got %0d pops, want 12", n_pop - p0); end
    drain();
  endtask

  task automatic test_wrap_load();
    logic [AW-1:0] want [3];
`ifdef QUARTER_WAVE_EN
    phase_init = 24'hFFC000;
    want[0] = 8'h00; want[1] = 8'h00; want[2] = 8'h01;
`else
    want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'h01;
`endif
    do_reset();
`ifdef QUARTER_WAVE_EN
    phase_init = 24'hFFC000;
`else
    phase_init = 24'hFF0000;
`endif
    sample_ready = 1'b1;
    en = 1'b1;
    phase_load = 1'b1;
    cycle();
    n_vec++;
    if (rom_cs0 !== 1'b0) begin n_err++; $display("[TB] FAIL load_no_issue: got %b, want 0", rom_cs0); end
    phase_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++;
      if (rom_cs0 !== 1'b1 || rom_addr0 !== want[i]) begin
        n_err++;
        $display("[TB] FAIL wrap_addr: got cs=%b addr=%h, want cs=1 addr=%h", rom_cs0, rom_addr0, want[i]);
      end
    end
    drain();
  endtask

  task automatic test_midop();
    int i0, p0;
    do_reset();
    sample_ready = 1'b1;
    en = 1'b1;
    i0 = n_issue;
    p0 = n_pop;
    cycle();
    cycle();
    en = 1'b0;
    repeat (6) cycle();
    n_vec += 4;
    if (n_issue - i0 != 2) begin n_err++; $display("[TB] FAIL en_off_issues: got %0d, want 2", n_issue - i0); end
    if (n_pop - p0 != 2) begin n_err++; $display("[TB] FAIL en_off_captured: got %0d, want 2", n_pop - p0); end
    if (sample_valid !== 1'b0) begin n_err++; $display("[TB] FAIL en_off_idle: got %b, want 0", sample_valid); end
    if (sb_q.size() != 0) begin n_err++; $display("[TB] FAIL en_off_left: got %0d, want 0", sb_q.size()); end
    sample_ready = 1'b0;
    en = 1'b1;
    repeat (3) cycle();
    rst0 = 1'b1;
    #1;
    n_vec += 3;
    if (sample_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_valid: got %b, want 0", sample_valid); end
    if (rom_cs0 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_cs: got %b, want 0", rom_cs0); end
    if (sample !== 16'h0000) begin n_err++; $display("[TB] FAIL rst_sample: got %h, want 0000", sample); end
    sb_q.delete();
    mp = '0;
    en = 1'b0;
    cycle();
    rst0 = 1'b0;
    sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_vec++;
      if (sample_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_stale: got %b, want 0", sample_valid); end
    end
  endtask

`ifdef QUARTER_WAVE_EN
  task automatic test_quarter_wave();
    do_reset();
    sample_ready = 1'b0;
    phase_init = 24'h804000;
    phase_load = 1'b1;
    en = 1'b1;
    cycle();
    phase_load = 1'b0;
    cycle();
    en = 1'b0;
    n_vec++;
    if (rom_addr0 !== 8'h01) begin n_err++; $display("[TB] FAIL qw_addr: got %h, want 01", rom_addr0); end
    repeat (3) cycle();
    n_vec++;
    if (sample !== 16'hFEFF) begin n_err++; $display("[TB] FAIL qw_negate: got %h, want FEFF", sample); end
    drain();
    phase_init = 24'h3FC000;
    phase_load = 1'b1;
    cycle();
    phase_load = 1'b0;
    en = 1'b1;
    cycle();
    n_vec++;
    if (rom_addr0 !== 8'hFF) begin n_err++; $display("[TB] FAIL qw_q0_end: got %h, want FF", rom_addr0); end
    cycle();
    n_vec++;
    if (rom_addr0 !== 8'hFF) begin n_err++; $display("[TB] FAIL qw_q1_start: got %h, want FF", rom_addr0); end
    cycle();
    n_vec++;
    if (rom_addr0 !== 8'hFE) begin n_err++; $display("[TB] FAIL qw_q1_next: got %h, want FE", rom_addr0); end
    drain();
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_wrap_load();
    test_midop();
`ifdef QUARTER_WAVE_EN
    test_quarter_wave();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
